// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-ported data memory between two requesters
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req0/1, we0/1, addr0/1,     per-port request; we/addr/wdata sampled at grant
//   wdata0/1
//   ack0/1, rdata0/1            one-cycle completion pulse, registered read data per port
//   busy                        high while an access is in ACCESS or DONE
//   MemRead, memWrite,          memory controls and latched address/data
//   Address, write_data
//   read_data                   memory read return
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          MemRead,
  output logic          memWrite,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t        r_state, w_next;
  logic          r_ptr, r_owner, r_we;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;
  logic          w_grant, w_win, w_last;
  assign w_grant = (r_state == IDLE) && (req0 || req1);
  // 1 selects port 1; the pointer only breaks ties when both ports request
  assign w_win   = (req0 && req1) ? r_ptr : req1;
  assign w_last  = (r_cnt == 4'd0);
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)   ? (w_grant ? ACCESS : IDLE) :
             (r_state == ACCESS) ? (w_last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_we    <= w_win ? we1 : we0;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
        r_cnt   <= 4'(WAIT_CYCLES);
        r_ptr   <= ~w_win;
      end
      if (r_state == ACCESS && !w_last) r_cnt <= r_cnt - 4'd1;
      if (r_state == ACCESS && w_last && !r_we && !r_owner) r_rdata0 <= read_data;
      if (r_state == ACCESS && w_last && !r_we &&  r_owner) r_rdata1 <= read_data;
    end
  assign MemRead    = (r_state == ACCESS) && !r_we;
  assign memWrite   = (r_state == ACCESS) &&  r_we;
  assign ack0       = (r_state == DONE) && !r_owner;
  assign ack1       = (r_state == DONE) &&  r_owner;
  assign busy       = (r_state == ACCESS) || (r_state == DONE);
  assign Address    = r_addr;
  assign write_data = r_wdata;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus corner-case sequences for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset, req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, read_data;
  logic        ack0, ack1, busy, MemRead, memWrite;
  logic [31:0] rdata0, rdata1, Address, write_data;
  int          n_vec = 0, n_bad = 0;
  localparam logic [31:0] J = 32'hDEADBEEF, C = 32'hCAFEF00D;
  always #5 clk = ~clk;
  mem_port_arbiter #(.WAIT_CYCLES(2), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .MemRead(MemRead), .memWrite(memWrite), .Address(Address),
    .write_data(write_data), .read_data(read_data)
  );
  typedef struct {
    string       nm;
    logic        rst, r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1, rd;
    logic [4:0]  e_ctl;
    logic [31:0] e_addr, e_wd, e_r0, e_r1;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(string nm, logic rst, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1, logic [31:0] rd,
                              logic [4:0] e_ctl, logic [31:0] e_addr, logic [31:0] e_wd,
                              logic [31:0] e_r0, logic [31:0] e_r1);
    vec_t v;
    v.nm = nm; v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.rd = rd;
    v.e_ctl = e_ctl; v.e_addr = e_addr; v.e_wd = e_wd; v.e_r0 = e_r0; v.e_r1 = e_r1;
    return v;
  endfunction
  task automatic chk(string nm, logic [132:0] act, logic [132:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // control bits are {MemRead, memWrite, ack0, ack1, busy}
  function automatic logic [4:0] ctl;
    return {MemRead, memWrite, ack0, ack1, busy};
  endfunction
  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; read_data = 0;
    vq.push_back(mk("reset", 1, 0,0,0,0, 0,0,0,0, 0, 5'b00000, 0,0,0,0));
    for (int i = 0; i < 20; i++) vq.push_back(mk("idle", 0, 0,0,0,0, 0,0,0,0, J, 5'b00000, 0,0,0,0));
    vq.push_back(mk("rd_grant", 0, 1,0,32'h10,0,    0,0,0,0, J, 5'b10001, 32'h10,0,0,0));
    vq.push_back(mk("rd_wait1", 0, 1,1,32'h99,32'h55, 0,0,0,0, J, 5'b10001, 32'h10,0,0,0));
    vq.push_back(mk("rd_wait2", 0, 1,1,32'h99,32'h55, 0,0,0,0, J, 5'b10001, 32'h10,0,0,0));
    vq.push_back(mk("rd_done",  0, 1,0,32'h10,0,    0,0,0,0, C, 5'b00101, 32'h10,0,C,0));
    vq.push_back(mk("rd_idle",  0, 0,0,0,0,         0,0,0,0, J, 5'b00000, 32'h10,0,C,0));
    vq.push_back(mk("rd_idle2", 0, 0,0,0,0,         0,0,0,0, J, 5'b00000, 32'h10,0,C,0));
    vq.push_back(mk("wr_grant", 0, 0,0,0,0, 1,1,32'h20,32'h12345678, J, 5'b01001, 32'h20,32'h12345678,C,0));
    vq.push_back(mk("wr_wait1", 0, 0,0,0,0, 1,0,32'h77,0,            J, 5'b01001, 32'h20,32'h12345678,C,0));
    vq.push_back(mk("wr_wait2", 0, 0,0,0,0, 1,0,32'h77,0,            J, 5'b01001, 32'h20,32'h12345678,C,0));
    vq.push_back(mk("wr_done",  0, 0,0,0,0, 1,1,32'h20,32'h12345678, C, 5'b00011, 32'h20,32'h12345678,C,0));
    vq.push_back(mk("wr_idle",  0, 0,0,0,0, 0,0,0,0,                 J, 5'b00000, 32'h20,32'h12345678,C,0));
    foreach (vq[i]) begin
      reset = vq[i].rst; req0 = vq[i].r0; we0 = vq[i].w0; addr0 = vq[i].a0; wdata0 = vq[i].d0;
      req1 = vq[i].r1; we1 = vq[i].w1; addr1 = vq[i].a1; wdata1 = vq[i].d1; read_data = vq[i].rd;
      tick();
      chk(vq[i].nm, {ctl(), Address, write_data, rdata0, rdata1},
          {vq[i].e_ctl, vq[i].e_addr, vq[i].e_wd, vq[i].e_r0, vq[i].e_r1});
    end
    // contention: both ports held from reset, grants alternate starting with port 0
    reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 1; addr0 = 32'h100; addr1 = 32'h200;
    tick();
    reset = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("contend%0d", n), 133'(ctl()),
          133'({(n % 10 >= 1 && n % 10 <= 3), (n % 10 >= 6 && n % 10 <= 8),
                (n % 10 == 4), (n % 10 == 9), (n % 5 != 0)}));
      if (ack0 && ack1) begin
        n_bad++;
        $display("FAIL both_acks: ack0=%b ack1=%b", ack0, ack1);
      end
    end
    // reset during the second ACCESS cycle aborts with no ack and clears the pointer
    req0 = 1; req1 = 0; addr0 = 32'h40;
    tick();
    chk("abort_acc1", 133'(ctl()), 133'(5'b10001));
    req0 = 0;
    tick();
    chk("abort_acc2", 133'(ctl()), 133'(5'b10001));
    reset = 1;
    tick();
    chk("abort_reset", {ctl(), Address}, {5'b00000, 32'h0});
    reset = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("abort_noack", 133'(ctl()), 133'(5'b00000));
    end
    req0 = 1; req1 = 1;
    tick();
    chk("ptr_reset_win0", {ctl(), Address}, {5'b10001, 32'h40});
    tick();
    tick();
    tick();
    chk("ptr_reset_ack0", 133'(ctl()), 133'(5'b00101));
    req0 = 0; req1 = 0;
    tick();
    chk("ptr_reset_idle", 133'(ctl()), 133'(5'b00000));
    // request dropped right after grant still completes exactly once
    req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'hA5;
    tick();
    chk("drop_grant", {ctl(), Address, write_data}, {5'b01001, 32'h80, 32'hA5});
    req0 = 0;
    for (int n = 2; n <= 8; n++) begin
      tick();
      chk($sformatf("drop%0d", n), 133'({ack0, ack1, busy}), 133'({n == 4, 1'b0, n <= 4}));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
